// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bit positions.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADC  = 4'b0010;
  localparam logic [3:0] OP_SBC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit positions inside the {Z,N,C,V} flag vector.
  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  function automatic logic is_shift_op(input logic [3:0] o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_core_addsub.sv
// Ripple-carry adder/subtractor; subtraction is a + ~b + cin with invert_b set.
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             invert_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v
);

  logic [WIDTH-1:0] w_b;
  logic             w_c_msb;

  assign w_b = invert_b ? ~b : b;

  // Ripple the carry bit by bit, remembering the carry into the MSB for overflow.
  always_comb begin
    logic c;
    // NOTE: every output gets a value before the loop so no latch is inferred.
    sum     = '0;
    w_c_msb = 1'b0;
    c       = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ w_b[i] ^ c;
      if (i == WIDTH - 1) w_c_msb = c;
      c = (a[i] & w_b[i]) | (c & (a[i] ^ w_b[i]));
    end
    cout = c;
  end

  assign v = w_c_msb ^ cout;

endmodule

// File: rtl/alu_seq_core.sv
// Registered WIDTH-bit ALU with valid/ready handshake, bit-serial shifts and a
// persistent carry flag for multi-word ADC/SBC chains.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_count;

  logic             w_accept;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic             w_cin, w_inv;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout, w_v;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c, w_alu_v;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_shift_out;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] res,
                                          input logic c, input logic v);
    logic [3:0] f;
    f     = '0;
    f[FZ] = (res == '0);
    f[FN] = res[WIDTH-1];
    f[FC] = c;
    f[FV] = v;
    return f;
  endfunction

  assign out_valid  = (r_state == DONE);
  assign in_ready   = (r_state == IDLE) && !out_valid;
  assign busy       = (r_state == SHIFT);
  assign result     = r_result;
  assign flags      = r_flags;
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = is_shift_op(op);
  assign w_amt      = b_in[SHW-1:0];

  // Adder control: carry-in and operand inversion chosen from the incoming opcode.
  always_comb begin
    w_cin = 1'b0;
    w_inv = 1'b0;
    case (op)
      OP_SUB: begin w_cin = 1'b1;        w_inv = 1'b1; end
      OP_ADC: begin w_cin = r_flags[FC]; w_inv = 1'b0; end
      OP_SBC: begin w_cin = r_flags[FC]; w_inv = 1'b1; end
      default: ;
    endcase
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (a_in),
    .b        (b_in),
    .cin      (w_cin),
    .invert_b (w_inv),
    .sum      (w_sum),
    .cout     (w_cout),
    .v        (w_v)
  );

  // Single-cycle result and C/V for arithmetic, logic and pass-through opcodes.
  always_comb begin
    w_alu_res = a_in;
    w_alu_c   = r_flags[FC];
    w_alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        w_alu_res = w_sum;
        w_alu_c   = w_cout;
        w_alu_v   = w_v;
      end
      OP_AND:  w_alu_res = a_in & b_in;
      OP_OR:   w_alu_res = a_in | b_in;
      OP_XOR:  w_alu_res = a_in ^ b_in;
      OP_PASS: w_alu_res = a_in;
      default: ;
    endcase
  end

  // One-position shift of the work register plus the bit that falls out.
  always_comb begin
    w_shift_next = r_work;
    w_shift_out  = 1'b0;
    case (r_op)
      OP_SLL: begin
        w_shift_next = {r_work[WIDTH-2:0], 1'b0};
        w_shift_out  = r_work[WIDTH-1];
      end
      OP_SRL: begin
        w_shift_next = {1'b0, r_work[WIDTH-1:1]};
        w_shift_out  = r_work[0];
      end
      OP_SRA: begin
        w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        w_shift_out  = r_work[0];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_next = (w_is_shift && w_amt != '0) ? SHIFT : DONE;
      SHIFT: if (r_count == SHW'(1)) w_state_next = DONE;
      DONE:  if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, run shifts, and register result/flags on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_op     <= '0;
      r_work   <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_work  <= a_in;
            r_count <= w_amt;
            if (!w_is_shift) begin
              r_result <= w_alu_res;
              r_flags  <= mk_flags(w_alu_res, w_alu_c, w_alu_v);
            end else if (w_amt == '0) begin
              r_result <= a_in;
              r_flags  <= mk_flags(a_in, r_flags[FC], 1'b0);
            end
          end
        end
        SHIFT: begin
          r_work  <= w_shift_next;
          r_count <= r_count - SHW'(1);
          if (r_count == SHW'(1)) begin
            r_result <= w_shift_next;
            r_flags  <= mk_flags(w_shift_next, w_shift_out, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=8: arithmetic flags, carry chaining,
// bit-serial shifts, backpressure, unused opcode and reset abort.
module tb_alu_seq_core;
  import alu_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc  = 0;

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; ends at the negedge after acceptance.
  task automatic send(input string tag, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = o;
    a_in     = a;
    b_in     = b;
    @(negedge clk);
    t_acc    = cyc;
    in_valid = 1'b0;
    op       = OP_ADD;
    a_in     = 8'hFF;
    b_in     = 8'h01;
  endtask

  // Wait (bounded) for out_valid, check latency/result/flags, then consume the result.
  task automatic recv(input string tag, input int exp_lat, input logic [7:0] exp_res,
                      input logic [3:0] exp_fl);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(cyc - t_acc + 1), 32'(exp_lat));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_flags"}, 32'(flags), 32'(exp_fl));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 4'b0000;
    a_in      = 8'h00;
    b_in      = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 32'h00);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // ADD with signed overflow: Z0 N1 C0 V1
    send("add", OP_ADD, 8'h7F, 8'h01);
    recv("add", 1, 8'h80, 4'b0101);

    // SUB equal operands: Z1 N0 C1 V0
    send("sub", OP_SUB, 8'h05, 8'h05);
    recv("sub", 1, 8'h00, 4'b1010);

    // SBC with C=1: 0x00-0x01 -> 0xFF, borrow (C0)
    send("sbc", OP_SBC, 8'h00, 8'h01);
    recv("sbc", 1, 8'hFF, 4'b0100);

    // ADC with C=0: 0x00+0x00 -> 0x00
    send("adc", OP_ADC, 8'h00, 8'h00);
    recv("adc", 1, 8'h00, 4'b1000);

    // SRA 0x90 by 3 -> 0xF2, busy for three cycles, result at cycle 4
    send("sra", OP_SRA, 8'h90, 8'h03);
    check("sra_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("sra_busy2", 32'(busy), 32'd1);
    check("sra_not_valid_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("sra_busy3", 32'(busy), 32'd1);
    recv("sra", 4, 8'hF2, 4'b0100);

    // SLL 0x81 by 1 -> 0x02, MSB shifted out into C
    send("sll", OP_SLL, 8'h81, 8'h01);
    recv("sll", 2, 8'h02, 4'b0010);

    // SRL with amount field 0 (b=0x08 masks to 0): result A, latency 1, C kept at 1
    send("srl0", OP_SRL, 8'h84, 8'h08);
    check("srl0_busy", 32'(busy), 32'd0);
    recv("srl0", 1, 8'h84, 4'b0110);

    // AND under backpressure: result held, no new acceptance
    send("and", OP_AND, 8'hF0, 8'h3C);
    check("and_result", 32'(result), 32'h30);
    check("and_flags", 32'(flags), 32'b0010);
    in_valid = 1'b1;
    op       = OP_ADD;
    a_in     = 8'hFF;
    b_in     = 8'h02;
    for (int i = 0; i < 5; i++) begin
      check("bp_result_hold", 32'(result), 32'h30);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    t_acc    = cyc;
    in_valid = 1'b0;
    // ADD 0xFF+0x02 -> 0x01, C1 V0
    recv("bp_add", 1, 8'h01, 4'b0010);

    // Unused opcode behaves as PASS: Z1, C kept at 1, V0
    send("op7", 4'b0111, 8'h00, 8'h5A);
    recv("op7", 1, 8'h00, 4'b1010);

    // Reset asserted mid-shift aborts the operation
    send("sll7", OP_SLL, 8'h01, 8'h07);
    repeat (2) @(negedge clk);
    check("sll7_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'h00);
    check("abort_flags", 32'(flags), 32'h0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid++;
    end
    check("abort_no_output", 32'(seen_valid), 32'd0);

    // Carry cleared by reset: ADC 0x01+0x01 -> 0x02
    send("adc_post_rst", OP_ADC, 8'h01, 8'h01);
    recv("adc_post_rst", 1, 8'h02, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
